// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - two-requester burst round-robin arbiter for the FIFO write port
// Optional statistics counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wfull_i,
    output logic              wr_en_o,
    output logic [DATA_W:0]   wr_data_o,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]       stat_beats0_o,
    output logic [15:0]       stat_beats1_o,
    output logic [15:0]       stat_stall_o,
`endif
    output logic [1:0]        owner_o
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    logic [1:0]       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic own_idx;
    logic own_valid;
    logic other_valid;
    logic owning;
    logic accept;
    logic stall;

    always_comb begin
        own_idx     = (state_q == ST_OWN1);
        own_valid   = own_idx ? req1_valid : req0_valid;
        other_valid = own_idx ? req0_valid : req1_valid;
        owning      = (state_q == ST_OWN0) || (state_q == ST_OWN1);
        accept      = owning && own_valid && !wfull_i;
        stall       = owning && own_valid && wfull_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // A stalled beat (owner valid, FIFO full) neither consumes budget nor releases the grant.
    always_comb begin
        logic             leave;
        logic [CNT_W-1:0] cnt_inc;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        leave       = 1'b0;
        cnt_inc     = burst_cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (rr_ptr_q ? req1_valid : !req0_valid) state_d = ST_OWN1;
                    else                                     state_d = ST_OWN0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_valid) begin
                    leave = 1'b1;
                end else if (accept) begin
                    burst_cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BURST_LEN)) leave = 1'b1;
                end
                if (leave) begin
                    rr_ptr_d    = ~own_idx;
                    burst_cnt_d = '0;
                    if (other_valid) state_d = own_idx ? ST_OWN0 : ST_OWN1;
                    else             state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        req0_ready = (state_q == ST_OWN0) && req0_valid && !wfull_i;
        req1_ready = (state_q == ST_OWN1) && req1_valid && !wfull_i;
        wr_en_o    = req0_ready || req1_ready;
        if (req1_ready)      wr_data_o = {1'b1, req1_data};
        else if (req0_ready) wr_data_o = {1'b0, req0_data};
        else                 wr_data_o = '0;
        owner_o    = state_q;
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] beats0_q, beats0_d;
    logic [15:0] beats1_q, beats1_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        beats0_d = beats0_q;
        beats1_d = beats1_q;
        stall_d  = stall_q;
        if (req0_ready && beats0_q != 16'hFFFF) beats0_d = beats0_q + 16'd1;
        if (req1_ready && beats1_q != 16'hFFFF) beats1_d = beats1_q + 16'd1;
        if (stall && stall_q != 16'hFFFF)       stall_d  = stall_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            beats0_q <= '0;
            beats1_q <= '0;
            stall_q  <= '0;
        end else begin
            beats0_q <= beats0_d;
            beats1_q <= beats1_d;
            stall_q  <= stall_d;
        end
    end

    assign stat_beats0_o = beats0_q;
    assign stat_beats1_o = beats1_q;
    assign stat_stall_o  = stall_q;
`endif

endmodule
